// File: rtl/psum_selection_decoder.sv
// Per-PE psum routing select decoder: marks chain-head rows (load from GIN) and
// chain-tail rows (drive GON) from per-row psum IDs and the layer filter height.
module psum_selection_decoder #(
    parameter int NUM_ROWS             = 12,
    parameter int NUM_COLS             = 14,
    parameter int PSUM_ROW_ID_BITWIDTH = 4,
    parameter int PSUM_COL_ID_BITWIDTH = 4
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst,
    input  logic [3:0]                                           i_layer_RS,
    input  logic [0:NUM_ROWS*PSUM_ROW_ID_BITWIDTH-1]             i_psum_row_id,
    input  logic [0:NUM_ROWS*NUM_COLS*PSUM_COL_ID_BITWIDTH-1]    i_psum_col_id,
    output logic [0:NUM_ROWS*NUM_COLS-1]                         o_ctrl_psum_in_sel_LNorGIN,
    output logic [0:NUM_ROWS*NUM_COLS-1]                         o_ctrl_psum_out_sel_GON
);

    // Both compare operands are widened to this so neither side is truncated.
    localparam int CMP_W = (PSUM_ROW_ID_BITWIDTH > 4) ? PSUM_ROW_ID_BITWIDTH : 4;

    logic [CMP_W-1:0]                    rs_ext;
    logic [CMP_W-1:0]                    row_id_ext [NUM_ROWS];
    logic [0:NUM_ROWS-1]                 row_first;
    logic [0:NUM_ROWS-1]                 row_last;
    logic [0:NUM_ROWS*NUM_COLS-1]        in_sel_next;
    logic [0:NUM_ROWS*NUM_COLS-1]        out_sel_next;

    // Column IDs play no part in the decode; reduced here only so they are consumed.
    logic unused_col_id;
    assign unused_col_id = ^i_psum_col_id;

    assign rs_ext = CMP_W'(i_layer_RS);

    always_comb begin
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            row_id_ext[r] = CMP_W'(i_psum_row_id[r*PSUM_ROW_ID_BITWIDTH +: PSUM_ROW_ID_BITWIDTH]);
        end
    end

    always_comb begin
        row_first = '0;
        row_last  = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            row_first[r] = (row_id_ext[r] == CMP_W'(1));
            row_last[r]  = (row_id_ext[r] == rs_ext);
        end
    end

    // Every PE in a row inherits that row's head/tail flags.
    always_comb begin
        in_sel_next  = '0;
        out_sel_next = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                in_sel_next[r*NUM_COLS + c]  = row_first[r];
                out_sel_next[r*NUM_COLS + c] = row_last[r];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ctrl_psum_in_sel_LNorGIN <= '0;
            o_ctrl_psum_out_sel_GON    <= '0;
        end else begin
            o_ctrl_psum_in_sel_LNorGIN <= in_sel_next;
            o_ctrl_psum_out_sel_GON    <= out_sel_next;
        end
    end

endmodule

// File: tb/tb_psum_selection_decoder.sv
// Directed checks of the psum select decoder on a 3x3 array with 4-bit IDs.
module tb_psum_selection_decoder;

    localparam int NR = 3;
    localparam int NC = 3;
    localparam int RW = 4;
    localparam int CW = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              rs;
    logic [0:NR*RW-1]        row_id;
    logic [0:NR*NC*CW-1]     col_id;
    logic [0:NR*NC-1]        in_sel;
    logic [0:NR*NC-1]        out_sel;

    int errors = 0;
    int checks = 0;

    psum_selection_decoder #(
        .NUM_ROWS(NR),
        .NUM_COLS(NC),
        .PSUM_ROW_ID_BITWIDTH(RW),
        .PSUM_COL_ID_BITWIDTH(CW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_layer_RS(rs),
        .i_psum_row_id(row_id),
        .i_psum_col_id(col_id),
        .o_ctrl_psum_in_sel_LNorGIN(in_sel),
        .o_ctrl_psum_out_sel_GON(out_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [0:NR*NC-1] obs, input logic [0:NR*NC-1] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with arbitrary inputs
        rst    = 1'b1;
        rs     = 4'd1;
        row_id = {4'd1, 4'd1, 4'd1};
        col_id = '1;
        step();
        step();
        check("reset_in", in_sel, 9'b000000000);
        check("reset_out", out_sel, 9'b000000000);

        // RS=3, IDs {1,2,3}
        rst    = 1'b0;
        rs     = 4'd3;
        row_id = {4'd1, 4'd2, 4'd3};
        col_id = '0;
        step();
        check("rs3_in", in_sel, 9'b111000000);
        check("rs3_out", out_sel, 9'b000000111);

        // RS=1, IDs {1,1,1}: head and tail coincide
        rs     = 4'd1;
        row_id = {4'd1, 4'd1, 4'd1};
        #1;
        check("no_comb_path_in", in_sel, 9'b111000000);
        check("no_comb_path_out", out_sel, 9'b000000111);
        step();
        check("rs1_in", in_sel, 9'b111111111);
        check("rs1_out", out_sel, 9'b111111111);

        // RS=0, IDs {0,1,2}: ID 0 never a head, but matches RS=0 as tail
        rs     = 4'd0;
        row_id = {4'd0, 4'd1, 4'd2};
        step();
        check("rs0_in", in_sel, 9'b000111000);
        check("rs0_out", out_sel, 9'b111000000);

        // Column IDs all ones must not change anything
        rs     = 4'd3;
        row_id = {4'd1, 4'd2, 4'd3};
        col_id = '1;
        step();
        check("colid_in", in_sel, 9'b111000000);
        check("colid_out", out_sel, 9'b000000111);

        // Reversed chain order across rows
        col_id = '0;
        row_id = {4'd3, 4'd0, 4'd1};
        step();
        check("rev_in", in_sel, 9'b000000111);
        check("rev_out", out_sel, 9'b111000000);

        // Maximum RS value
        rs     = 4'd15;
        row_id = {4'd15, 4'd15, 4'd0};
        step();
        check("rs15_in", in_sel, 9'b000000000);
        check("rs15_out", out_sel, 9'b111111000);

        // Mid-run reset pulse with RS=1, IDs {1,1,1} held
        rs     = 4'd1;
        row_id = {4'd1, 4'd1, 4'd1};
        step();
        check("pre_rst_in", in_sel, 9'b111111111);
        check("pre_rst_out", out_sel, 9'b111111111);
        rst = 1'b1;
        step();
        check("mid_rst_in", in_sel, 9'b000000000);
        check("mid_rst_out", out_sel, 9'b000000000);
        rst = 1'b0;
        step();
        check("post_rst_in", in_sel, 9'b111111111);
        check("post_rst_out", out_sel, 9'b111111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
